// File: rtl/download_copier.sv
// download_copier: copies a finished SPI download buffer into system memory.
// Optional running checksum of copied bytes: define DOWNLOAD_COPIER_CHECKSUM_EN.
module download_copier #(
    parameter logic [15:0] DEST_BASE = 16'h0000,
    parameter logic [15:0] MAX_SIZE  = 16'h8000,
    parameter int          READ_LAT  = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        downloading,
    input  logic [15:0] size,
    output logic [14:0] buf_a,
    input  logic [7:0]  buf_dout,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_data,
    output logic        mem_we,
    input  logic        mem_ack,
    output logic        busy,
    output logic        done,
    output logic [7:0]  checksum
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        READ,
        WRITE,
        FIN
    } state_t;

    localparam logic [1:0] LAT_LAST = 2'(READ_LAT - 1);

    state_t      state;
    state_t      state_nx;
    logic        dl_meta;
    logic        dl_sync;
    logic        dl_prev;
    logic        rise;
    logic        fall;
    logic [15:0] idx;
    logic [15:0] len;
    logic [15:0] len_in;
    logic [1:0]  lat_cnt;
    logic        wr_first;
    logic [7:0]  data_q;
    logic        last;
    logic [7:0]  wr_byte;

    assign rise    = dl_sync & ~dl_prev;
    assign fall    = ~dl_sync & dl_prev;
    assign len_in  = (size > MAX_SIZE) ? MAX_SIZE : size;
    assign last    = ((idx + 16'd1) == len);
    // First WRITE cycle takes the byte straight off the buffer; later cycles
    // replay the captured copy so the write data cannot drift while waiting.
    assign wr_byte = wr_first ? buf_dout : data_q;

    // Two-flop synchronizer plus edge-detect history for downloading
    always_ff @(posedge clk) begin
        if (reset) begin
            dl_meta <= 1'b0;
            dl_sync <= 1'b0;
            dl_prev <= 1'b0;
        end else begin
            dl_meta <= downloading;
            dl_sync <= dl_meta;
            dl_prev <= dl_sync;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic; a new download start always wins over copy progress
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (rise) state_nx = LOAD;
            end
            LOAD: begin
                if (fall) state_nx = (len_in == 16'd0) ? FIN : READ;
            end
            READ: begin
                if (rise) state_nx = LOAD;
                else if (lat_cnt == LAT_LAST) state_nx = WRITE;
            end
            WRITE: begin
                if (rise) state_nx = LOAD;
                else if (mem_ack) state_nx = last ? FIN : READ;
            end
            FIN: begin
                state_nx = rise ? LOAD : IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Copy datapath: length latch, byte index, read latency count, data capture
    always_ff @(posedge clk) begin
        if (reset) begin
            idx      <= 16'd0;
            len      <= 16'd0;
            lat_cnt  <= 2'd0;
            wr_first <= 1'b0;
            data_q   <= 8'd0;
        end else begin
            lat_cnt  <= (state == READ) ? lat_cnt + 2'd1 : 2'd0;
            wr_first <= (state == READ);
            if (state == LOAD && fall) len <= len_in;
            if (state == LOAD) begin
                idx <= 16'd0;
            end else if (state == WRITE && mem_ack && !last && !rise) begin
                idx <= idx + 16'd1;
            end
            if (state == WRITE && wr_first) data_q <= buf_dout;
        end
    end

`ifdef DOWNLOAD_COPIER_CHECKSUM_EN
    logic [7:0] sum_q;

    // Running sum of accepted bytes, restarted for every new download
    always_ff @(posedge clk) begin
        if (reset) begin
            sum_q <= 8'd0;
        end else if (state == LOAD) begin
            sum_q <= 8'd0;
        end else if (state == WRITE && mem_ack) begin
            sum_q <= sum_q + wr_byte;
        end
    end

    assign checksum = sum_q;
`else
    assign checksum = 8'h00;
`endif

    // Moore outputs decoded from state
    always_comb begin
        buf_a    = idx[14:0];
        busy     = 1'b0;
        done     = 1'b0;
        mem_we   = 1'b0;
        mem_addr = 16'd0;
        mem_data = 8'd0;
        unique case (state)
            IDLE: ;
            LOAD: busy = 1'b1;
            READ: busy = 1'b1;
            WRITE: begin
                busy     = 1'b1;
                mem_we   = 1'b1;
                mem_addr = DEST_BASE + idx;
                mem_data = wr_byte;
            end
            FIN: done = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_download_copier.sv
// tb_download_copier: directed vector table plus reset and abort sequences.
// Buffer and memory are modelled here; ack latency is programmable per vector.
module tb_download_copier;

    localparam logic [15:0] DEST = 16'h1000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        downloading = 1'b0;
    logic [15:0] size = 16'd0;
    logic [14:0] buf_a;
    logic [7:0]  buf_dout = 8'd0;
    logic [15:0] mem_addr;
    logic [7:0]  mem_data;
    logic        mem_we;
    logic        mem_ack = 1'b0;
    logic        busy;
    logic        done;
    logic [7:0]  checksum;

    download_copier #(
        .DEST_BASE(DEST),
        .MAX_SIZE (16'h8000),
        .READ_LAT (1)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .downloading(downloading),
        .size       (size),
        .buf_a      (buf_a),
        .buf_dout   (buf_dout),
        .mem_addr   (mem_addr),
        .mem_data   (mem_data),
        .mem_we     (mem_we),
        .mem_ack    (mem_ack),
        .busy       (busy),
        .done       (done),
        .checksum   (checksum)
    );

    always #5 clk = ~clk;

    logic [7:0] buf_mem [0:32767];

    // Buffer with one cycle read latency
    always @(posedge clk) buf_dout <= buf_mem[buf_a];

    int checks = 0;
    int errors = 0;

    int          ack_delay = 0;
    bit          spur = 1'b0;
    int          wr_count = 0;
    int          done_cnt = 0;
    logic [15:0] last_addr = 16'd0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, act, exp);
        end
    endtask

    // Memory side: ack generation, write checking and hold-stability
    int          wcnt = 0;
    logic        prev_we = 1'b0;
    logic        prev_acc = 1'b0;
    logic [15:0] prev_addr = 16'd0;
    logic [7:0]  prev_data = 8'd0;

    always @(negedge clk) begin
        if (done) done_cnt++;
        if (prev_we && !prev_acc && mem_we) begin
            check("hold_addr", {16'd0, mem_addr}, {16'd0, prev_addr});
            check("hold_data", {24'd0, mem_data}, {24'd0, prev_data});
        end
        if (mem_we) begin
            if (wcnt >= ack_delay) begin
                mem_ack = 1'b1;
                wcnt = 0;
            end else begin
                mem_ack = 1'b0;
                wcnt++;
            end
        end else begin
            mem_ack = spur;
            wcnt = 0;
        end
        if (mem_we && mem_ack) begin
            check("wr_addr", {16'd0, mem_addr}, {16'd0, DEST + 16'(wr_count)});
            check("wr_data", {24'd0, mem_data},
                  {24'd0, buf_mem[15'(wr_count)]});
            last_addr = mem_addr;
            wr_count++;
        end
        prev_we   = mem_we;
        prev_acc  = mem_we && mem_ack;
        prev_addr = mem_addr;
        prev_data = mem_data;
    end

    typedef struct {
        logic [15:0] size;
        logic [7:0]  pat;
        int          delay;
        bit          spur;
        int          exp_n;
        logic [15:0] exp_last;
    } vec_t;

    vec_t tbl [6];

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    function automatic logic [7:0] model_sum(input int n);
        logic [7:0] s = 8'd0;
        for (int i = 0; i < n; i++) s = s + buf_mem[i];
`ifdef DOWNLOAD_COPIER_CHECKSUM_EN
        return s;
`else
        return 8'h00;
`endif
    endfunction

    task automatic fill(input logic [7:0] pat);
        for (int i = 0; i < 32768; i++) begin
            if (pat == 8'd0) buf_mem[i] = 8'((i + 1) * 17);
            else buf_mem[i] = 8'(i) ^ pat;
        end
    endtask

    task automatic wait_done(input int budget, input string name);
        int n = 0;
        while (done_cnt == 0 && n < budget) begin
            tick(1);
            n++;
        end
        check(name, {31'd0, done_cnt != 0}, 32'd1);
    endtask

    task automatic wait_writes(input int target, input int budget,
                               input string name);
        int n = 0;
        while (wr_count < target && n < budget) begin
            tick(1);
            n++;
        end
        check(name, wr_count, target);
    endtask

    task automatic run_vec(input vec_t v);
        fill(v.pat);
        ack_delay = v.delay;
        spur = v.spur;
        wr_count = 0;
        done_cnt = 0;
        downloading = 1'b1;
        size = v.size;
        tick(5);
        check("busy_dl", {31'd0, busy}, 32'd1);
        downloading = 1'b0;
        wait_done(v.exp_n * (v.delay + 3) + 50, "done_seen");
        tick(3);
        check("n_writes", wr_count, v.exp_n);
        check("n_done", done_cnt, 32'd1);
        check("checksum", {24'd0, checksum}, {24'd0, model_sum(v.exp_n)});
        check("busy_end", {31'd0, busy}, 32'd0);
        check("we_end", {31'd0, mem_we}, 32'd0);
        if (v.exp_n > 0) check("last_addr", {16'd0, last_addr},
                               {16'd0, v.exp_last});
        spur = 1'b0;
    endtask

    initial begin
        tbl[0] = '{16'd4,      8'h00, 0, 1'b0, 4,     16'h1003};
        tbl[1] = '{16'd0,      8'h00, 0, 1'b1, 0,     16'h0000};
        tbl[2] = '{16'd1,      8'h05, 0, 1'b1, 1,     16'h1000};
        tbl[3] = '{16'd8,      8'h3C, 5, 1'b0, 8,     16'h1007};
        tbl[4] = '{16'd3,      8'h96, 2, 1'b1, 3,     16'h1002};
        tbl[5] = '{16'hFFFF,   8'hA5, 0, 1'b0, 32768, 16'h8FFF};

        fill(8'h00);
        tick(3);
        check("rst_we", {31'd0, mem_we}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_addr", {16'd0, mem_addr}, 32'd0);
        check("rst_data", {24'd0, mem_data}, 32'd0);
        check("rst_bufa", {17'd0, buf_a}, 32'd0);
        check("rst_sum", {24'd0, checksum}, 32'd0);
        reset = 1'b0;
        tick(2);

        for (int i = 0; i < 6; i++) run_vec(tbl[i]);

`ifdef DOWNLOAD_COPIER_CHECKSUM_EN
        fill(8'h00);
        check("sum_4bytes", {24'd0, model_sum(4)}, 32'hAA);
`endif

        // Reset in the middle of a copy
        fill(8'h21);
        ack_delay = 3;
        wr_count = 0;
        done_cnt = 0;
        downloading = 1'b1;
        size = 16'd8;
        tick(5);
        downloading = 1'b0;
        wait_writes(2, 100, "rst_mid_pre");
        reset = 1'b1;
        tick(1);
        check("rstm_we", {31'd0, mem_we}, 32'd0);
        check("rstm_busy", {31'd0, busy}, 32'd0);
        check("rstm_done", {31'd0, done}, 32'd0);
        tick(2);
        reset = 1'b0;
        tick(30);
        check("rstm_writes", wr_count, 32'd2);
        check("rstm_nodone", done_cnt, 32'd0);

        // New download starts during a copy: abort, then copy the new file
        fill(8'h3C);
        ack_delay = 5;
        wr_count = 0;
        done_cnt = 0;
        downloading = 1'b1;
        size = 16'd8;
        tick(5);
        downloading = 1'b0;
        wait_writes(2, 100, "abort_pre");
        downloading = 1'b1;
        tick(10);
        check("abort_writes", wr_count, 32'd2);
        check("abort_nodone", done_cnt, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd1);
        check("abort_we", {31'd0, mem_we}, 32'd0);
        fill(8'h77);
        ack_delay = 0;
        wr_count = 0;
        size = 16'd3;
        downloading = 1'b0;
        wait_done(100, "abort_new_done");
        tick(3);
        check("abort_new_n", wr_count, 32'd3);
        check("abort_new_done1", done_cnt, 32'd1);
        check("abort_new_sum", {24'd0, checksum}, {24'd0, model_sum(3)});
        check("abort_new_last", {16'd0, last_addr}, 32'h1002);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
